// File: rtl/blit_write_coalescer_if.sv
// rtl/blit_write_coalescer_if.sv - pixel-write input and merged-word output bus of the write coalescer
interface blit_write_coalescer_if #(
  parameter int ADDR_W = 26,
  parameter int DATA_W = 32
);
  localparam int BYTES = DATA_W / 8;

  // Stage 4 -> coalescer: byte-wide pixel writes
  logic              p4_write;
  logic [ADDR_W-1:0] p4_address;
  logic [7:0]        p4_wdata;
  logic              p4_ready;

  // Coalescer -> stage 5: merged word writes towards the SDRAM arbiter
  logic              p5_write;
  logic              p5_ready;
  logic [ADDR_W-1:0] p5_address;
  logic [BYTES-1:0]  p5_wstrb;
  logic [DATA_W-1:0] p5_wdata;

  // Environment side: the pixel pipeline source plus the arbiter sink
  modport master (
    output p4_write, p4_address, p4_wdata,
    input  p4_ready,
    input  p5_write, p5_address, p5_wstrb, p5_wdata,
    output p5_ready
  );

  // Coalescer side
  modport slave (
    input  p4_write, p4_address, p4_wdata,
    output p4_ready,
    output p5_write, p5_address, p5_wstrb, p5_wdata,
    input  p5_ready
  );
endinterface

// File: rtl/blit_write_coalescer.sv
// rtl/blit_write_coalescer.sv - multi-line byte-write combiner between blitter stage 4 and SDRAM write port
module blit_write_coalescer #(
  parameter int ADDR_W    = 26,
  parameter int DATA_W    = 32,
  parameter int NUM_LINES = 2,
  parameter int TIMEOUT   = 15
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                flush,
  output logic                idle,
  blit_write_coalescer_if.slave bus
);
  localparam int BYTES = DATA_W / 8;
  localparam int LSB   = $clog2(BYTES);
  localparam int TAG_W = ADDR_W - LSB;
  localparam int IDX_W = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;

  // Open combine lines
  logic [NUM_LINES-1:0] line_valid;
  logic [TAG_W-1:0]     line_tag  [NUM_LINES];
  logic [DATA_W-1:0]    line_data [NUM_LINES];
  logic [BYTES-1:0]     line_strb [NUM_LINES];
  logic [7:0]           line_age  [NUM_LINES];
  logic [IDX_W-1:0]     vptr;

  // Output word register
  logic                 out_valid;
  logic [ADDR_W-1:0]    out_address;
  logic [BYTES-1:0]     out_strb;
  logic [DATA_W-1:0]    out_data;

  // Incoming pixel decode
  logic [TAG_W-1:0]     in_tag;
  logic [LSB-1:0]       in_lane;
  logic [LSB+2:0]       lane_shift;
  logic [DATA_W-1:0]    lane_data;
  logic [DATA_W-1:0]    lane_dmask;
  logic [BYTES-1:0]     lane_strb;

  logic                 slot_free;
  logic                 accept;
  logic                 hit_any;
  logic [IDX_W-1:0]     hit_idx;
  logic                 free_any;
  logic [IDX_W-1:0]     free_idx;
  logic                 miss_evict;
  logic                 alloc;

  logic [NUM_LINES-1:0] cand;
  logic                 full_any;
  logic [IDX_W-1:0]     full_idx;
  logic                 age0_any;
  logic [IDX_W-1:0]     age0_idx;
  logic                 cand_any;
  logic [IDX_W-1:0]     cand_idx;
  logic                 drain_go;
  logic [IDX_W-1:0]     drain_idx;
  logic                 load;
  logic [IDX_W-1:0]     load_idx;

  assign in_tag     = bus.p4_address[ADDR_W-1:LSB];
  assign in_lane    = bus.p4_address[LSB-1:0];
  assign lane_shift = {in_lane, 3'b000};
  assign lane_data  = DATA_W'(bus.p4_wdata) << lane_shift;
  assign lane_dmask = DATA_W'(8'hFF) << lane_shift;
  assign lane_strb  = BYTES'(1) << in_lane;

  // The output slot can take a new word when it is empty or being handed off now
  assign slot_free  = !out_valid || bus.p5_ready;
  assign accept     = bus.p4_write && slot_free;
  assign miss_evict = accept && !hit_any && (&line_valid);
  assign alloc      = accept && !hit_any && !(&line_valid);

  // Tag lookup and lowest free line; descending loop so the lowest index wins
  always_comb begin
    hit_any  = 1'b0;
    hit_idx  = '0;
    free_any = 1'b0;
    free_idx = '0;
    for (int i = NUM_LINES - 1; i >= 0; i--) begin
      if (line_valid[i] && (line_tag[i] == in_tag)) begin
        hit_any = 1'b1;
        hit_idx = IDX_W'(i);
      end
      if (!line_valid[i]) begin
        free_any = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  // Drain selection: full lines first, then timed-out lines, then anything under flush.
  // A line being merged into this cycle is not eligible; it drains on a later cycle.
  always_comb begin
    cand     = '0;
    full_any = 1'b0;
    full_idx = '0;
    age0_any = 1'b0;
    age0_idx = '0;
    cand_any = 1'b0;
    cand_idx = '0;
    for (int i = NUM_LINES - 1; i >= 0; i--) begin
      cand[i] = line_valid[i] && !(accept && hit_any && (hit_idx == IDX_W'(i)));
      if (cand[i]) begin
        cand_any = 1'b1;
        cand_idx = IDX_W'(i);
        if (&line_strb[i]) begin
          full_any = 1'b1;
          full_idx = IDX_W'(i);
        end
        if (line_age[i] == 8'd0) begin
          age0_any = 1'b1;
          age0_idx = IDX_W'(i);
        end
      end
    end
    drain_go  = slot_free && !miss_evict && (full_any || age0_any || (flush && cand_any));
    drain_idx = full_any ? full_idx : (age0_any ? age0_idx : cand_idx);
    load      = miss_evict || drain_go;
    load_idx  = miss_evict ? vptr : drain_idx;
  end

  // Line state: merge on hit, (re)fill on allocate or eviction, drop on drain, age idle lines
  always_ff @(posedge clock) begin
    if (reset) begin
      line_valid <= '0;
      vptr       <= '0;
      for (int i = 0; i < NUM_LINES; i++) begin
        line_tag[i]  <= '0;
        line_data[i] <= '0;
        line_strb[i] <= '0;
        line_age[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_LINES; i++) begin
        if (accept && hit_any && (hit_idx == IDX_W'(i))) begin
          line_data[i] <= (line_data[i] & ~lane_dmask) | lane_data;
          line_strb[i] <= line_strb[i] | lane_strb;
          line_age[i]  <= 8'(TIMEOUT);
        end else if ((alloc && (free_idx == IDX_W'(i))) ||
                     (miss_evict && (vptr == IDX_W'(i)))) begin
          line_valid[i] <= 1'b1;
          line_tag[i]   <= in_tag;
          line_data[i]  <= lane_data;
          line_strb[i]  <= lane_strb;
          line_age[i]   <= 8'(TIMEOUT);
        end else begin
          if (drain_go && (drain_idx == IDX_W'(i))) begin
            line_valid[i] <= 1'b0;
          end
          if (line_valid[i] && (line_age[i] != 8'd0)) begin
            line_age[i] <= line_age[i] - 8'd1;
          end
        end
      end
      if (miss_evict) begin
        vptr <= (vptr == IDX_W'(NUM_LINES - 1)) ? '0 : vptr + IDX_W'(1);
      end
    end
  end

  // Output register: load an evicted or drained line, hold under backpressure, clear after handoff
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid   <= 1'b0;
      out_address <= '0;
      out_strb    <= '0;
      out_data    <= '0;
    end else if (load) begin
      out_valid   <= 1'b1;
      out_address <= {line_tag[load_idx], {LSB{1'b0}}};
      out_strb    <= line_strb[load_idx];
      out_data    <= line_data[load_idx];
    end else if (bus.p5_ready) begin
      out_valid   <= 1'b0;
    end
  end

  assign bus.p4_ready   = slot_free;
  assign bus.p5_write   = out_valid;
  assign bus.p5_address = out_address;
  assign bus.p5_wstrb   = out_strb;
  assign bus.p5_wdata   = out_data;
  assign idle           = !(|line_valid) && !out_valid;
endmodule

// File: tb/tb_blit_write_coalescer.sv
// tb/tb_blit_write_coalescer.sv - directed self-checking bench for blit_write_coalescer
module tb_blit_write_coalescer;
  localparam int ADDR_W  = 26;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 15;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic flush2 = 1'b0;
  logic flush4 = 1'b0;
  logic idle2;
  logic idle4;
  int   vectors = 0;
  int   miscompares = 0;
  int   cnt;

  blit_write_coalescer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus2 ();
  blit_write_coalescer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus4 ();

  blit_write_coalescer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_LINES(2), .TIMEOUT(TIMEOUT)) u_dut2 (
    .clock(clock), .reset(reset), .flush(flush2), .idle(idle2), .bus(bus2.slave)
  );

  blit_write_coalescer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_LINES(4), .TIMEOUT(TIMEOUT)) u_dut4 (
    .clock(clock), .reset(reset), .flush(flush4), .idle(idle4), .bus(bus4.slave)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One accepted pixel write; returns 1ns after the accepting edge
  task automatic wr(input bit sel, input logic [ADDR_W-1:0] a, input logic [7:0] d);
    if (sel) begin
      bus4.p4_write = 1'b1; bus4.p4_address = a; bus4.p4_wdata = d;
    end else begin
      bus2.p4_write = 1'b1; bus2.p4_address = a; bus2.p4_wdata = d;
    end
    @(negedge clock);
    check("wr_p4_ready", sel ? bus4.p4_ready : bus2.p4_ready, 1);
    @(posedge clock);
    #1;
    bus2.p4_write = 1'b0;
    bus4.p4_write = 1'b0;
  endtask

  task automatic chk_word2(input string tag, input logic [ADDR_W-1:0] a, input logic [3:0] s, input logic [31:0] d);
    check({tag, "_write"}, bus2.p5_write, 1);
    check({tag, "_addr"},  bus2.p5_address, a);
    check({tag, "_wstrb"}, bus2.p5_wstrb, s);
    check({tag, "_wdata"}, bus2.p5_wdata, d);
  endtask

  task automatic chk_word4(input string tag, input logic [ADDR_W-1:0] a, input logic [3:0] s, input logic [31:0] d);
    check({tag, "_write"}, bus4.p5_write, 1);
    check({tag, "_addr"},  bus4.p5_address, a);
    check({tag, "_wstrb"}, bus4.p5_wstrb, s);
    check({tag, "_wdata"}, bus4.p5_wdata, d);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus2.p4_write = 1'b0; bus2.p4_address = '0; bus2.p4_wdata = '0; bus2.p5_ready = 1'b1;
    bus4.p4_write = 1'b0; bus4.p4_address = '0; bus4.p4_wdata = '0; bus4.p5_ready = 1'b1;

    // Reset state
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    check("rst_p5_write", bus2.p5_write, 0);
    check("rst_p5_addr",  bus2.p5_address, 0);
    check("rst_p5_wstrb", bus2.p5_wstrb, 0);
    check("rst_p5_wdata", bus2.p5_wdata, 0);
    check("rst_idle2",    idle2, 1);
    check("rst_idle4",    idle4, 1);
    check("rst_p4_ready", bus2.p4_ready, 1);

    // 1. Combine four bytes into one word
    wr(0, 26'h100, 8'h11);
    check("t1_no_early", bus2.p5_write, 0);
    wr(0, 26'h101, 8'h22);
    wr(0, 26'h102, 8'h33);
    wr(0, 26'h103, 8'h44);
    check("t1_not_same_cycle", bus2.p5_write, 0);
    tick();
    chk_word2("t1", 26'h100, 4'hF, 32'h44332211);
    tick();
    check("t1_single_word", bus2.p5_write, 0);
    check("t1_idle", idle2, 1);

    // 2. Multi-line: the fourth write evicts line 0, 0x200 stays open
    wr(0, 26'h100, 8'hA1);
    wr(0, 26'h200, 8'hB2);
    wr(0, 26'h101, 8'hC3);
    wr(0, 26'h300, 8'hD4);
    chk_word2("t2_evict", 26'h100, 4'h3, 32'h0000C3A1);
    tick();
    check("t2_evict_done", bus2.p5_write, 0);
    check("t2_open_lines", idle2, 0);
    flush2 = 1'b1;
    tick();
    chk_word2("t2_fl0", 26'h300, 4'h1, 32'h000000D4);
    tick();
    chk_word2("t2_fl1", 26'h200, 4'h1, 32'h000000B2);
    flush2 = 1'b0;
    tick();
    check("t2_end_write", bus2.p5_write, 0);
    check("t2_end_idle", idle2, 1);

    // 3. Timeout drain
    wr(0, 26'h205, 8'hAB);
    cnt = 0;
    while (!bus2.p5_write && cnt < 40) begin
      tick();
      cnt++;
    end
    check("t3_latency", cnt, TIMEOUT + 1);
    chk_word2("t3", 26'h204, 4'h2, 32'h0000AB00);
    tick();
    check("t3_idle", idle2, 1);

    // 4. Overwrite, then eviction held under backpressure
    wr(0, 26'h500, 8'h55);
    wr(0, 26'h400, 8'h01);
    wr(0, 26'h400, 8'h02);
    bus2.p5_ready = 1'b0;
    wr(0, 26'h600, 8'h66);
    chk_word2("t4_evict", 26'h400, 4'h1, 32'h00000002);
    bus2.p4_write = 1'b1; bus2.p4_address = 26'h700; bus2.p4_wdata = 8'h77;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("t4_hold_p4_ready", bus2.p4_ready, 0);
      chk_word2("t4_hold", 26'h400, 4'h1, 32'h00000002);
      @(posedge clock);
      #1;
    end
    bus2.p5_ready = 1'b1;
    @(negedge clock);
    check("t4_release_p4_ready", bus2.p4_ready, 1);
    @(posedge clock);
    #1;
    bus2.p4_write = 1'b0;
    chk_word2("t4_evict2", 26'h500, 4'h1, 32'h00000055);
    tick();
    check("t4_evict2_done", bus2.p5_write, 0);
    flush2 = 1'b1;
    tick();
    chk_word2("t4_fl0", 26'h700, 4'h1, 32'h00000077);
    tick();
    chk_word2("t4_fl1", 26'h600, 4'h1, 32'h00000066);
    flush2 = 1'b0;
    tick();
    check("t4_end_idle", idle2, 1);

    // 5. Flush three lines of the four-line instance
    wr(1, 26'h104, 8'h5A);
    wr(1, 26'h209, 8'h6B);
    wr(1, 26'h30F, 8'h7C);
    check("t5_open", idle4, 0);
    flush4 = 1'b1;
    tick();
    chk_word4("t5_w0", 26'h104, 4'h1, 32'h0000005A);
    tick();
    chk_word4("t5_w1", 26'h208, 4'h2, 32'h00006B00);
    tick();
    chk_word4("t5_w2", 26'h30C, 4'h8, 32'h7C000000);
    check("t5_idle_before", idle4, 0);
    flush4 = 1'b0;
    tick();
    check("t5_end_write", bus4.p5_write, 0);
    check("t5_end_idle", idle4, 1);

    // 6. Reset with two lines open and a held output word
    bus2.p5_ready = 1'b0;
    wr(0, 26'h800, 8'h88);
    wr(0, 26'h900, 8'h99);
    wr(0, 26'hA00, 8'hAA);
    check("t6_pending", bus2.p5_write, 1);
    check("t6_pending_addr", bus2.p5_address, 26'h900);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6_rst_write", bus2.p5_write, 0);
    check("t6_rst_idle",  idle2, 1);
    check("t6_rst_addr",  bus2.p5_address, 0);
    check("t6_rst_wstrb", bus2.p5_wstrb, 0);
    check("t6_rst_wdata", bus2.p5_wdata, 0);
    bus2.p5_ready = 1'b1;
    cnt = 0;
    repeat (TIMEOUT + 5) begin
      tick();
      if (bus2.p5_write) cnt++;
    end
    check("t6_no_stale", cnt, 0);
    check("t6_final_idle", idle2, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/blit_write_coalescer.md
Name: blit_write_coalescer

Overview:
Parametrised multi-line write combiner that sits between the blitter pixel pipeline (stage 4) and the SDRAM arbiter write port (stage 5). It merges byte-wide pixel writes into NUM_LINES open word buffers of DATA_W bits. It emits a merged word on eviction, on full byte strobe, on per-line timeout, or on an explicit flush. The output is held by a ready/valid handshake, and the input is backpressured so that no write is ever lost.

Parameters:
ADDR_W, 26, byte address width.
DATA_W, 32, output word width in bits; must be a power of two, 32 or 64. BYTES = DATA_W/8, LSB = log2(BYTES).
NUM_LINES, 2, number of open combine lines; 1 to 8.
TIMEOUT, 15, idle cycles before a line becomes eligible for drain; 1 to 255.

Ports:
clock  input  1  clock; all logic is posedge.
reset  input  1  synchronous, active-high reset.
p4_write  input  1  pixel write request.
p4_address  input  ADDR_W  byte address of the pixel.
p4_wdata  input  8  pixel value.
p4_ready  output  1  the write is accepted when p4_write && p4_ready.
flush  input  1  level; while high, all open lines are drained.
p5_write  output  1  output word valid.
p5_ready  input  1  the arbiter accepts the word when p5_write && p5_ready.
p5_address  output  ADDR_W  word-aligned address; low LSB bits are 0.
p5_wstrb  output  BYTES  byte enables.
p5_wdata  output  DATA_W  merged data.
idle  output  1  no valid line, and p5_write is low.

Behaviour:
- Per-line state: valid, tag (the upper ADDR_W-LSB address bits), data[DATA_W], strb[BYTES], age[8].
- Output register slot: "free" means !p5_write || p5_ready in the current cycle.
- p4_ready = slot free. This is combinational and depends only on p5_write and p5_ready.
- Lane of an incoming pixel = p4_address[LSB-1:0].
- Accepted write, hit (a valid line's tag matches):
  - Write byte lane = p4_wdata, replacing any earlier byte in that lane.
  - Set strb bit. Reload age = TIMEOUT.
- Accepted write, miss, free line exists: allocate the lowest-index invalid line. Set strb to the single lane bit, data to the lane byte (other lanes 0), age = TIMEOUT.
- Accepted write, miss, all lines valid:
  - The victim is the line at the round-robin pointer vptr. The victim is loaded into the output register, and p5_write=1 next cycle.
  - The new pixel takes that line. vptr advances, wrapping at NUM_LINES.
- Drain (only when the slot is free and no miss-eviction occurs this cycle): choose one line, in priority order:
  1. The lowest-index valid line with strb all ones.
  2. The lowest-index valid line with age==0.
  3. If flush is high, the lowest-index valid line.
  - The chosen line is moved to the output register and invalidated.
- A line hit by an accepted write in the same cycle is excluded from drain selection. It merges instead.
- A line whose strb becomes all ones via a hit drains on a later free cycle, not the same one.
- Age decrements by 1 per cycle on valid lines that are not written, saturating at 0.
- At most one word is emitted per cycle.
- Output hold: while p5_write && !p5_ready, p5_address, p5_wstrb and p5_wdata are held stable. No input is accepted and no drain occurs.
- p5_write drops the cycle after handshake unless a new word is loaded.
- Latency: eviction or drain decision in cycle N → word on p5 in cycle N+1.
- Reset, cycle after: p5_write=0, p5_address=0, p5_wstrb=0, p5_wdata=0, all lines invalid, vptr=0, idle=1. Reset mid-operation discards pending lines and any held output word without emitting them.
- idle is combinational.
- Correctness invariant: the bytes emitted on p5 equal the bytes written on p4, last write per byte wins. No byte is lost or duplicated.

Test Plan:
1. Combine: write 0x11,0x22,0x33,0x44 to 0x100..0x103 (DATA_W=32) with p5_ready=1. Required: exactly one word, addr 0x100, wstrb 0xF, wdata 0x44332211, emitted the cycle after the 4th write is merged.
2. Multi-line: write to 0x100, 0x200, 0x101, then 0x300 with NUM_LINES=2. Required: the 0x300 write evicts line 0 (0x100, wstrb 0x3). 0x200 remains open.
3. Timeout: a single write of 0xAB to 0x205, then idle. Required: p5 word addr 0x204, wstrb 0x2, wdata 0x0000AB00, appearing TIMEOUT+1 cycles after the write. Afterwards idle=1.
4. Overwrite and backpressure:
   - Write 0x01 then 0x02 to 0x400. Required: wdata byte0=0x02.
   - Hold p5_ready=0 for 5 cycles with an eviction pending. Required: the p5 outputs stay stable, p4_ready=0, and no input is lost.
5. Flush: three lines open with NUM_LINES=4, raise flush. Required: three words, in index order, on consecutive cycles with p5_ready=1. idle rises the cycle after the last handshake.
6. Reset mid-stream: reset asserted with two lines open and p5_write=1. Required: the next cycle has p5_write=0 and idle=1, and no stale word appears afterward.
